// File: rtl/seg7s2p_if.sv
// rtl/seg7s2p_if.sv - seven-segment serial link bundle (s_clk, s_clrn, sout, EN)
interface seg7s2p_if;
  logic s_clk;
  logic s_clrn;
  logic sout;
  logic EN;

  modport master (output s_clk, s_clrn, sout, EN);
  modport slave  (input  s_clk, s_clrn, sout, EN);
endinterface

// File: rtl/seg7s2p.sv
// rtl/seg7s2p.sv - seven-segment serial link receiver and decoder; SEG7S2P_LEN_CHECK_EN enables frame length check
module seg7s2p #(
  parameter int DATA_BITS   = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7s2p_if.slave    link,
  output logic [31:0] num,
  output logic [7:0]  dot,
  output logic [7:0]  bad_digit,
  output logic        valid,
  output logic        frame_err
);

  localparam logic [6:0] FULL_CNT = 7'(DATA_BITS);
  localparam logic [6:0] MAX_CNT  = 7'd127;

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, clrn_sync, sout_sync, en_sync;
  logic                   sclk_s, clrn_s, sout_s, en_s;
  logic                   sclk_prev, en_prev;
  logic                   sclk_rise, en_rise, sout_d, clrn_d;

  state_t                 state, state_d;
  logic [DATA_BITS-1:0]   sr, sr_d;
  logic [6:0]             cnt, cnt_d;
  logic [31:0]            num_d;
  logic [7:0]             dot_d, bad_d;
  logic                   take, reject;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign clrn_s = clrn_sync[SYNC_STAGES-1];
  assign sout_s = sout_sync[SYNC_STAGES-1];
  assign en_s   = en_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      clrn_sync <= '0;
      sout_sync <= '0;
      en_sync   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], link.s_clk};
      clrn_sync <= {clrn_sync[SYNC_STAGES-2:0], link.s_clrn};
      sout_sync <= {sout_sync[SYNC_STAGES-2:0], link.sout};
      en_sync   <= {en_sync[SYNC_STAGES-2:0], link.EN};
    end
  end

  // sout and s_clrn ride one extra stage so they stay aligned with the registered edge flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev <= 1'b0;
      en_prev   <= 1'b0;
      sclk_rise <= 1'b0;
      en_rise   <= 1'b0;
      sout_d    <= 1'b0;
      clrn_d    <= 1'b0;
    end else begin
      sclk_prev <= sclk_s;
      en_prev   <= en_s;
      sclk_rise <= sclk_s & ~sclk_prev;
      en_rise   <= en_s & ~en_prev;
      sout_d    <= sout_s;
      clrn_d    <= clrn_s;
    end
  end

  // returns {unmatched, nibble}; the dp bit is ignored for matching
  function automatic logic [4:0] decode(input logic [7:0] seg);
    case ({seg[7:1], 1'b1})
      8'h03:   decode = 5'h00;
      8'h9F:   decode = 5'h01;
      8'h25:   decode = 5'h02;
      8'h0D:   decode = 5'h03;
      8'h99:   decode = 5'h04;
      8'h49:   decode = 5'h05;
      8'h41:   decode = 5'h06;
      8'h1F:   decode = 5'h07;
      8'h01:   decode = 5'h08;
      8'h09:   decode = 5'h09;
      8'h11:   decode = 5'h0A;
      8'hC1:   decode = 5'h0B;
      8'h63:   decode = 5'h0C;
      8'h85:   decode = 5'h0D;
      8'h61:   decode = 5'h0E;
      8'h71:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    num_d   = num;
    dot_d   = dot;
    bad_d   = bad_digit;
    take    = 1'b0;
    reject  = 1'b0;

    if (!clrn_d) begin
      sr_d    = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      if (sclk_rise) begin
        sr_d = {sr[DATA_BITS-2:0], sout_d};
        if (cnt != MAX_CNT) cnt_d = cnt + 7'd1;
        case (state)
          IDLE:    state_d = (FULL_CNT == 7'd1) ? FULL : SHIFT;
          SHIFT:   state_d = (cnt == FULL_CNT - 7'd1) ? FULL : SHIFT;
          FULL:    state_d = OVER;
          default: state_d = OVER;
        endcase
      end

      // latch sees the post-shift frame when both edges land in one cycle
      if (en_rise) begin
`ifdef SEG7S2P_LEN_CHECK_EN
        take   = (state_d == FULL);
        reject = (state_d != FULL);
`else
        take   = 1'b1;
`endif
        cnt_d   = '0;
        state_d = IDLE;
        if (take) begin
          for (int i = 0; i < 8; i++) begin
            {bad_d[i], num_d[4*i +: 4]} = decode(sr_d[8*i +: 8]);
            dot_d[i] = ~sr_d[8*i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      num       <= '0;
      dot       <= '0;
      bad_digit <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      cnt       <= cnt_d;
      num       <= num_d;
      dot       <= dot_d;
      bad_digit <= bad_d;
      valid     <= take;
      frame_err <= reject;
    end
  end

endmodule

// File: tb/tb_seg7s2p.sv
// tb/tb_seg7s2p.sv - directed bench for seg7s2p with a frame-level reference model
module tb_seg7s2p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] num;
  logic [7:0]  dot, bad_digit;
  logic        valid, frame_err;

  always #5 clk = ~clk;

  seg7s2p_if link_if ();

  seg7s2p dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link      (link_if.slave),
    .num       (num),
    .dot       (dot),
    .bad_digit (bad_digit),
    .valid     (valid),
    .frame_err (frame_err)
  );

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic [63:0] m_sr = '0;
  int          m_cnt = 0;
  logic [47:0] e_old = '0;
  logic [47:0] e_new = '0;
  int          due = 0;
  bit          has_ev = 1'b0;
  bit          acc = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] make_frame(input logic [31:0] v, input logic [7:0] dp_on);
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = seg_tab[v[4*i +: 4]] & ~{7'b0, dp_on[i]};
    return f;
  endfunction

  // {bad_digit, dot, num} that a display would read from a 64-bit frame
  function automatic logic [47:0] m_decode(input logic [63:0] f);
    logic [31:0] n;
    logic [7:0]  d, b, byt;
    n = '0; d = '0; b = '1;
    for (int i = 0; i < 8; i++) begin
      byt  = f[8*i +: 8];
      d[i] = ~byt[0];
      for (int k = 0; k < 16; k++) begin
        if (seg_tab[k][7:1] == byt[7:1]) begin
          n[4*i +: 4] = 4'(k);
          b[i] = 1'b0;
        end
      end
    end
    return {b, d, n};
  endfunction

  task automatic compare();
    logic [47:0] cur;
    bit ev, ef;
    cur = (cyc >= due) ? e_new : e_old;
    ev  = has_ev && (cyc == due) && acc;
    ef  = has_ev && (cyc == due) && !acc;
    check("valid", {31'b0, valid}, {31'b0, ev});
    check("frame_err", {31'b0, frame_err}, {31'b0, ef});
    check("num", num, cur[31:0]);
    check("dot", {24'b0, dot}, {24'b0, cur[39:32]});
    check("bad_digit", {24'b0, bad_digit}, {24'b0, cur[47:40]});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (chk_en) compare();
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic model_shift(input logic b);
    m_sr = {m_sr[62:0], b};
    if (m_cnt < 127) m_cnt++;
  endtask

  task automatic model_latch();
    logic [47:0] dec;
    dec = m_decode(m_sr);
    if (cyc >= due) e_old = e_new;
`ifdef SEG7S2P_LEN_CHECK_EN
    acc = (m_cnt == 64);
`else
    acc = 1'b1;
`endif
    e_new  = acc ? dec : e_old;
    due    = cyc + 4;
    has_ev = 1'b1;
    m_cnt  = 0;
  endtask

  task automatic send_bit(input logic b);
    link_if.sout = b;
    steps(2);
    link_if.s_clk = 1'b1;
    model_shift(b);
    steps(4);
    link_if.s_clk = 1'b0;
    steps(3);
  endtask

  // sends the low nbits of f, most significant first
  task automatic send_bits(input logic [63:0] f, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic latch();
    link_if.EN = 1'b1;
    model_latch();
    steps(4);
    link_if.EN = 1'b0;
    steps(4);
  endtask

  task automatic clear_link();
    link_if.s_clrn = 1'b0;
    m_sr  = '0;
    m_cnt = 0;
    steps(4);
    link_if.s_clrn = 1'b1;
    steps(4);
  endtask

  logic [63:0] f;
  int          c0;

  initial begin
    link_if.s_clk  = 1'b0;
    link_if.s_clrn = 1'b1;
    link_if.sout   = 1'b0;
    link_if.EN     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset num", num, 32'h0);
    check("reset dot/bad", {16'b0, dot, bad_digit}, 32'h0);
    check("reset valid/ferr", {30'b0, valid, frame_err}, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    steps(6);

    send_bits(make_frame(32'h12345678, 8'h00), 64);
    latch();
    check("t1 num", num, 32'h12345678);
    check("t1 dot/bad", {16'b0, dot, bad_digit}, 32'h0);

    send_bits(64'hFFFF_FFFF_FFFF_FF00, 64);
    latch();
    check("t2 num", num, 32'h00000008);
    check("t2 dot", {24'b0, dot}, 32'h01);
    check("t2 bad", {24'b0, bad_digit}, 32'hFE);

    send_bits(make_frame(32'h55555555, 8'hFF), 20);
    clear_link();
    send_bits(make_frame(32'hDEADBEEF, 8'h00), 64);
    latch();
    check("t3 num", num, 32'hDEADBEEF);

    clear_link();
    send_bits(make_frame(32'h12345678, 8'h00), 63);
    latch();
`ifdef SEG7S2P_LEN_CHECK_EN
    check("t4 num held", num, 32'hDEADBEEF);
`else
    check("t4 num short", num, 32'h72345678);
`endif

    send_bits(make_frame(32'h99999999, 8'h00), 30);
    link_if.sout = 1'b0;
    rst_n = 1'b0;
    e_old = '0; e_new = '0; has_ev = 1'b0;
    m_sr = '0; m_cnt = 0;
    #1;
    check("t5 reset num", num, 32'h0);
    check("t5 reset dot/bad", {16'b0, dot, bad_digit}, 32'h0);
    steps(1);
    rst_n = 1'b1;
    steps(6);
    send_bits(make_frame(32'hCAFE0001, 8'h81), 64);
    latch();
    check("t5 num", num, 32'hCAFE0001);
    check("t5 dot", {24'b0, dot}, 32'h81);

    send_bits(64'h3F, 6);
    send_bits(make_frame(32'hA5B6C7D8, 8'h00), 64);
    latch();

    f = make_frame(32'h0F1E2D3C, 8'h5A);
    send_bits(f >> 1, 63);
    link_if.sout = f[0];
    steps(2);
    link_if.s_clk = 1'b1;
    link_if.EN    = 1'b1;
    model_shift(f[0]);
    model_latch();
    c0 = cyc;
    for (int j = 1; j <= 6; j++) begin
      steps(1);
      check("t7 valid latency", {31'b0, valid}, {31'b0, (cyc - c0) == 4});
    end
    link_if.s_clk = 1'b0;
    link_if.EN    = 1'b0;
    steps(4);
    check("t7 num", num, 32'h0F1E2D3C);
    check("t7 dot", {24'b0, dot}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7s2p.md
# seg7s2p

Serial-to-parallel receiver for the seven-segment serial link driven by the `seg` display block. It is the far end of the `s_clk`/`s_clrn`/`sout`/`EN` link. It samples the link on the system clock, reassembles the 64-bit segment frame, and decodes each 8-bit segment pattern back to a hex nibble. It serves as a loopback monitor in simulation and on the board, so the displayed value can be checked against the value the core sent.

## Interface
- `DATA_BITS`, 64: frame length in bits; fixed at 8 digits × 8 bits.
- `SYNC_STAGES`, 2: synchronizer flops per link input; minimum 2.
- `clk` input 1: system clock.
- `rst_n` input 1: reset; one clock, asynchronous assert, active-low.
- `s_clk` input 1: link shift clock; asynchronous to `clk`.
- `s_clrn` input 1: link clear, active-low.
- `sout` input 1: link serial data.
- `EN` input 1: link latch strobe, active-high.
- `num` output 32: decoded digits; `num[4i+3:4i]` is digit i.
- `dot` output 8: decimal points, active-high; `dot[i]` belongs to digit i.
- `bad_digit` output 8: bit i set if digit i's pattern is not in the table.
- `valid` output 1: one-cycle pulse when `num`/`dot`/`bad_digit` update.
- `frame_err` output 1: one-cycle pulse when a frame is rejected (length check only).

## Operation
- **Synchronization:**
  - `s_clk`, `s_clrn`, `sout` and `EN` each pass through `SYNC_STAGES` flops.
  - A registered previous value of the synchronized signal gives the edge detection.
- **Shift:**
  - On each synchronized `s_clk` rising edge, `sr <= {sr[62:0], sout_s}`, so the frame arrives MSB first.
  - On the same edge, the 7-bit counter `cnt` increments and saturates at 127.
- **Clear:** while synchronized `s_clrn` is 0, `sr` and `cnt` are cleared, and this overrides any shift. `num`, `dot` and `bad_digit` are not affected.
- **Latch:**
  - On a synchronized `EN` rising edge, the frame is accepted: it is decoded into the output registers and `valid` pulses.
  - `cnt` then resets to 0.
- **Frame layout:** byte i is `sr[8i+7:8i]`, so `sr[63:56]` is digit 7.
  - Segment bits are `{a,b,c,d,e,f,g,dp}` from bit 7 down to bit 0, all active-low.
- **Decode table** (byte with dp bit forced to 1 → nibble):
  - 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F
  - 8:01, 9:09, A:11, B:C1, C:63, D:85, E:61, F:71
- **Unmatched pattern:** the digit decodes to 0 and `bad_digit[i]` is set to 1.
- **Decimal point:** `dot[i] = ~byte_i[0]`.
- **State machine:**
  - States: IDLE (cnt==0), SHIFT (0<cnt<64), FULL (cnt==64), OVER (cnt>64).
  - IDLE→SHIFT on the first `s_clk` edge.
  - SHIFT→FULL on the 64th edge.
  - FULL→OVER on a further edge.
  - Any state →IDLE on clear, on a latch, or on reset.
- **Simultaneous events:**
  - `s_clk` edge and `EN` edge detected in the same cycle: the shift is applied first, and the latch uses the post-shift `sr`/`cnt`.
  - Clear together with `EN` edge: clear wins and there is no latch.
- **Reset values:** `rst_n` low asynchronously clears all synchronizers, `sr`, `cnt`, `num`=0, `dot`=0, `bad_digit`=0, `valid`=0 and `frame_err`=0.
- **Reset mid-frame:** the partial frame is discarded, and reception restarts at IDLE after release.

## Timing
- Link input to detected edge: `SYNC_STAGES`+1 `clk` cycles.
- `EN` rising at the pin to `valid` high: `SYNC_STAGES`+2 cycles (4 at the default).
- `num`, `dot` and `bad_digit` change in the same cycle `valid` is high and hold until the next accepted frame.
- `s_clk` high and low phases must each be ≥ `SYNC_STAGES`+1 `clk` periods. Faster edges are not guaranteed to be counted.
- `sout` must be stable from one `clk` period before the `s_clk` rise until one period after it. Stability is measured in synchronized time, and the equal synchronizer depth makes it hold.
- Back-to-back frames are supported: the first `s_clk` edge after a latch begins the next frame.

## Configuration
- `SEG7S2P_LEN_CHECK_EN` defined:
  - The latch is accepted only in FULL (cnt==64).
  - In any other state, the outputs hold, `valid` stays 0, `frame_err` pulses for one cycle in the cycle `valid` would have pulsed, and `cnt` resets.
- `SEG7S2P_LEN_CHECK_EN` undefined:
  - Every `EN` edge latches the current `sr` regardless of `cnt`.
  - `frame_err` is tied to 0.

## Test plan
- **Frame for 0x12345678, dp all off:** shift 64 bits MSB first, then EN → one `valid` pulse; `num`=0x12345678, `dot`=0, `bad_digit`=0.
- **Byte 0 = 0x00 (pattern 8 with dp on), others 0xFF:** latch → `num`=0x00000008, `dot`=0x01; `bad_digit`=0xFE (0xFF is not a valid pattern).
- **`s_clrn` low after 20 bits, then a full 64-bit frame for 0xDEADBEEF:** → `num`=0xDEADBEEF.
- **EN after 63 bits:**
  - With `SEG7S2P_LEN_CHECK_EN`: → `frame_err` pulses, `valid`=0, `num` unchanged.
  - Without it: → `valid` pulses.
- **`rst_n` low for 1 cycle after 30 bits:** all outputs are 0 immediately; a following full frame for 0xCAFE0001 decodes correctly.
- **`s_clk` edge and EN edge arriving in the same synchronized cycle on the 64th bit:** → accepted with all 64 bits, and `valid` is high 4 cycles after EN.
